// File: rtl/tx_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_resp_pkg
// Description : Shared types and width helpers for the TX response
//               scheduler (state enum, pointer/count/timeout widths).
// Revision    : 1.0 - initial release
// ============================================================================
package tx_resp_pkg;

    // Scheduler states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_e;

    // FIFO read/write pointer width for a given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy count width: one extra bit so that "full" (count == depth)
    // is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of the Busy-rise timeout counter (counts 0 .. timeout-1).
    function automatic int tmo_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    // Defaults matching the block's default parameterisation.
    localparam int c_DEF_DEPTH        = 4;
    localparam int c_DEF_BUSY_TIMEOUT = 32;
    localparam int c_PTR_W            = ptr_width(c_DEF_DEPTH);
    localparam int c_CNT_W            = cnt_width(c_DEF_DEPTH);
    localparam int c_TMO_W            = tmo_width(c_DEF_BUSY_TIMEOUT);

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_fifo
// Description : Byte FIFO accepting 0-3 bytes per cycle and releasing at
//               most one byte per cycle. Admission decisions are made by the
//               caller; this block trusts i_push_n to fit.
// Revision    : 1.0 - initial release
// Ports       :
//   clk         in   clock
//   rst_n       in   asynchronous reset, active-low (empties the FIFO)
//   i_push_n    in   number of bytes to write this cycle (0..3)
//   i_push_data in   bytes to write, slot 0 in the least significant byte
//   i_pop       in   remove the head byte this cycle
//   o_head      out  byte at the head of the FIFO
//   o_count     out  current occupancy in bytes
// ============================================================================
module resp_fifo
    import tx_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    i_push_n,
    input  logic [3*DATA_WIDTH-1:0]       i_push_data,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_head,
    output logic [cnt_width(DEPTH)-1:0]   o_count
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_CNT_W = cnt_width(DEPTH);
    localparam int c_SLOTS = 3;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic [DATA_WIDTH-1:0] w_slot_data [c_SLOTS];
    logic [c_PTR_W-1:0]    w_slot_addr [c_SLOTS];
    logic                  w_slot_en   [c_SLOTS];

    // Slot k lands at wr_ptr+k; pointer arithmetic wraps modulo DEPTH
    // because DEPTH is a power of two. DEPTH >= 4 keeps the three slot
    // addresses distinct.
    for (genvar k = 0; k < c_SLOTS; k++) begin : g_slot
        assign w_slot_data[k] = i_push_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_slot_addr[k] = r_wr_ptr + c_PTR_W'(k);
        assign w_slot_en[k]   = (i_push_n > 2'(k));
    end

    // Storage is not reset: only locations below the count are ever read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_SLOTS; k++) begin
            if (w_slot_en[k]) begin
                r_mem[w_slot_addr[k]] <= w_slot_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(i_push_n);
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(i_push_n) - c_CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/tx_resp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tx_resp_sched
// Description : Shares the UART TX path between register-file reads and ALU
//               results. Responses are split into bytes, queued, and sent
//               one at a time; each byte waits for a full Busy rise/fall
//               handshake (or a rise timeout) before the next is released.
// Revision    : 1.0 - initial release
// Ports       :
//   CLK          in   reference-domain clock
//   RST          in   asynchronous reset, active-low
//   RdData       in   register-file read data
//   RdData_Valid in   1-cycle strobe qualifying RdData (1 byte)
//   ALU_OUT      in   ALU result
//   OUT_Valid    in   1-cycle strobe qualifying ALU_OUT (2 bytes, LSB first)
//   Busy         in   UART TX busy, already synchronized into CLK
//   TX_P_DATA    out  byte offered to the TX synchronizer (held until next pop)
//   TX_D_VALID   out  1-cycle send pulse
//   sched_idle   out  FIFO empty and FSM idle
//   ovf_err      out  sticky: a response was dropped for lack of space
//   tmo_err      out  sticky: Busy failed to rise after a pulse
// ============================================================================
module tx_resp_sched
    import tx_resp_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ALU_WIDTH    = 16,
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_Valid,
    input  logic                  Busy,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VALID,
    output logic                  sched_idle,
    output logic                  ovf_err,
    output logic                  tmo_err
);

    localparam int c_CNT_W = cnt_width(DEPTH);
    localparam int c_TMO_W = tmo_width(BUSY_TIMEOUT);

    tx_state_e                 r_state;
    tx_state_e                 w_next_state;
    logic [c_TMO_W-1:0]        r_tmo_cnt;
    logic [DATA_WIDTH-1:0]     r_tx_data;
    logic                      r_tx_valid;
    logic                      r_ovf;
    logic                      r_tmo;

    logic                      w_pop;
    logic                      w_tmo_hit;
    logic [c_CNT_W-1:0]        w_count;
    logic [DATA_WIDTH-1:0]     w_head;
    logic [c_CNT_W-1:0]        w_free;
    logic [c_CNT_W-1:0]        w_free_after_rd;
    logic                      w_rd_ok;
    logic                      w_alu_ok;
    logic                      w_drop;
    logic [1:0]                w_push_n;
    logic [3*DATA_WIDTH-1:0]   w_push_data;
    logic [DATA_WIDTH-1:0]     w_alu_lsb;
    logic [DATA_WIDTH-1:0]     w_alu_msb;

    assign w_alu_lsb = ALU_OUT[DATA_WIDTH-1:0];
    assign w_alu_msb = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];

    // ------------------------------------------------------------------
    // Admission. Space freed by a same-cycle pop is usable immediately.
    // The read response has priority; the ALU response is admitted only
    // if both of its bytes fit in what remains, otherwise it is dropped.
    // A pop implies count >= 1, so w_free never exceeds DEPTH.
    // ------------------------------------------------------------------
    assign w_free          = c_CNT_W'(DEPTH) - w_count + c_CNT_W'(w_pop);
    assign w_rd_ok         = RdData_Valid && (w_free != '0);
    assign w_free_after_rd = w_free - c_CNT_W'(w_rd_ok);
    assign w_alu_ok        = OUT_Valid && (w_free_after_rd >= c_CNT_W'(2));
    assign w_drop          = (RdData_Valid && !w_rd_ok) || (OUT_Valid && !w_alu_ok);
    assign w_push_n        = {1'b0, w_rd_ok} + {w_alu_ok, 1'b0};

    // Pack bytes in send order: read byte first, then ALU LSB, ALU MSB.
    always_comb begin
        w_push_data = '0;
        if (w_rd_ok) begin
            w_push_data = {w_alu_msb, w_alu_lsb, RdData};
        end else begin
            w_push_data = {{DATA_WIDTH{1'b0}}, w_alu_msb, w_alu_lsb};
        end
    end

    resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RST),
        .i_push_n    (w_push_n),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // ------------------------------------------------------------------
    // Send FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                // Busy still high means the previous frame is in flight.
                if ((w_count != '0) && !Busy) begin
                    w_pop        = 1'b1;
                    w_next_state = PULSE;
                end
            end
            PULSE: begin
                w_next_state = WAIT_HI;
            end
            WAIT_HI: begin
                if (Busy) begin
                    w_next_state = WAIT_LO;
                end else if (r_tmo_cnt == c_TMO_W'(BUSY_TIMEOUT - 1)) begin
                    // Byte is abandoned, not retried.
                    w_tmo_hit    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            WAIT_LO: begin
                if (!Busy) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tmo_cnt <= '0;
        end else if (r_state == PULSE) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == WAIT_HI) && !Busy && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_tx_data <= w_head;
            end
            r_tx_valid <= (w_next_state == PULSE);
            r_ovf      <= r_ovf | w_drop;
            r_tmo      <= r_tmo | w_tmo_hit;
        end
    end

    assign TX_P_DATA  = r_tx_data;
    assign TX_D_VALID = r_tx_valid;
    assign sched_idle = (w_count == '0) && (r_state == IDLE);
    assign ovf_err    = r_ovf;
    assign tmo_err    = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_tx_resp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_resp_sched
// Description : Self-checking bench for tx_resp_sched. A queue-based
//               reference model predicts every output each cycle; directed
//               scenarios add literal expectations; a randomized phase
//               stresses admission, handshake and timeout behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_resp_sched;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int T     = 32;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] RdData;
    logic          RdData_Valid;
    logic [15:0]   ALU_OUT;
    logic          OUT_Valid;
    logic          Busy;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VALID;
    logic          sched_idle;
    logic          ovf_err;
    logic          tmo_err;

    tx_resp_sched #(
        .DATA_WIDTH   (DW),
        .ALU_WIDTH    (16),
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (T)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .OUT_Valid    (OUT_Valid),
        .Busy         (Busy),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VALID   (TX_D_VALID),
        .sched_idle   (sched_idle),
        .ovf_err      (ovf_err),
        .tmo_err      (tmo_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 50)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // UART-side Busy responder: after each pulse, raise Busy rise_dly
    // cycles later and hold it hold_len cycles. Manual mode drives man_busy.
    // ------------------------------------------------------------------
    bit auto_busy = 1'b1;
    bit man_busy  = 1'b0;
    int rise_dly  = 3;
    int hold_len  = 10;

    initial begin : busy_responder
        bit auto_val;
        int dly_left;
        int hold_left;
        Busy      = 1'b0;
        auto_val  = 1'b0;
        dly_left  = -1;
        hold_left = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!auto_busy) begin
                auto_val  = 1'b0;
                dly_left  = -1;
                hold_left = 0;
                Busy      = man_busy;
            end else begin
                if (TX_D_VALID) dly_left = rise_dly;
                else if (dly_left > 0) dly_left--;
                if (dly_left == 0) begin
                    auto_val  = 1'b1;
                    hold_left = hold_len;
                    dly_left  = -1;
                end else if (hold_left > 0) begin
                    hold_left--;
                    if (hold_left == 0) auto_val = 1'b0;
                end
                Busy = auto_val;
            end
        end
    end

    int busy_falls = 0;
    initial begin : fall_counter
        logic busy_d;
        busy_d = 1'b0;
        forever begin
            @(posedge CLK);
            if (busy_d && !Busy) busy_falls++;
            busy_d = Busy;
        end
    end

    // ------------------------------------------------------------------
    // Reference model. The link is "owned" from the pop until the Busy
    // handshake finishes; age counts edges since the pop. Busy is watched
    // for a rise during ages 2..T+1, then for the fall.
    // ------------------------------------------------------------------
    logic [DW-1:0] mq[$];
    bit            owned;
    bit            rose;
    int            age;
    logic          m_valid;
    logic [DW-1:0] m_data;
    bit            m_ovf;
    bit            m_tmo;
    bit            chk_en = 1'b0;

    initial begin : model
        int free;
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                mq.delete();
                owned = 0; rose = 0; age = 0;
                m_valid = 1'b0; m_data = '0; m_ovf = 0; m_tmo = 0;
            end else begin
                m_valid = 1'b0;
                if (!owned) begin
                    if (mq.size() != 0 && !Busy) begin
                        m_data  = mq.pop_front();
                        m_valid = 1'b1;
                        owned   = 1; age = 0; rose = 0;
                    end
                end else begin
                    age++;
                    if (age >= 2) begin
                        if (!rose) begin
                            if (Busy) rose = 1;
                            else if (age == T + 1) begin
                                m_tmo = 1;
                                owned = 0;
                            end
                        end else if (!Busy) begin
                            owned = 0;
                        end
                    end
                end
                free = DEPTH - mq.size();
                if (RdData_Valid) begin
                    if (free >= 1) begin mq.push_back(RdData); free--; end
                    else m_ovf = 1;
                end
                if (OUT_Valid) begin
                    if (free >= 2) begin
                        mq.push_back(ALU_OUT[7:0]);
                        mq.push_back(ALU_OUT[15:8]);
                    end else m_ovf = 1;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("model_valid", {31'b0, TX_D_VALID}, {31'b0, m_valid});
                check("model_data",  {24'b0, TX_P_DATA},  {24'b0, m_data});
                check("model_idle",  {31'b0, sched_idle}, {31'b0, (!owned && mq.size() == 0)});
                check("model_ovf",   {31'b0, ovf_err},    {31'b0, m_ovf});
                check("model_tmo",   {31'b0, tmo_err},    {31'b0, m_tmo});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic strobe(input bit rd, input logic [7:0] rb, input bit alu, input logic [15:0] ab);
        @(posedge CLK); #1;
        RdData_Valid = rd; RdData = rb;
        OUT_Valid = alu;   ALU_OUT = ab;
        @(posedge CLK); #1;
        RdData_Valid = 1'b0; OUT_Valid = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int max_cyc, output logic [7:0] d);
        bit seen = 0;
        d = '0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge CLK);
            if (TX_D_VALID === 1'b1) begin
                seen = 1;
                d = TX_P_DATA;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: got no pulse in %0d cycles, expected one", name, max_cyc);
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge CLK);
            if (sched_idle === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: sched_idle got 0 for %0d cycles, expected 1", name, max_cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        logic [7:0] d;
        int falls0;
        int pulses;
        bit heavy;

        RST = 1'b0; RdData = '0; RdData_Valid = 1'b0; ALU_OUT = '0; OUT_Valid = 1'b0;
        repeat (3) @(posedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        check("rst_valid", {31'b0, TX_D_VALID}, 32'd0);
        check("rst_data",  {24'b0, TX_P_DATA},  32'h00);
        check("rst_idle",  {31'b0, sched_idle}, 32'd1);
        check("rst_ovf",   {31'b0, ovf_err},    32'd0);
        check("rst_tmo",   {31'b0, tmo_err},    32'd0);
        @(posedge CLK); #1 RST = 1'b1;

        // 1: single read, pulse one cycle after the strobe edge
        auto_busy = 1; rise_dly = 3; hold_len = 10;
        strobe(1, 8'hA5, 0, 16'h0);
        @(negedge CLK);
        check("t1_no_pulse_yet", {31'b0, TX_D_VALID}, 32'd0);
        check("t1_queued_busy",  {31'b0, sched_idle}, 32'd0);
        @(negedge CLK);
        check("t1_pulse",      {31'b0, TX_D_VALID}, 32'd1);
        check("t1_data",       {24'b0, TX_P_DATA},  32'hA5);
        @(negedge CLK);
        check("t1_pulse_len",  {31'b0, TX_D_VALID}, 32'd0);
        check("t1_data_hold",  {24'b0, TX_P_DATA},  32'hA5);
        wait_idle("t1_idle", 40);

        // 2: ALU result, LSB then MSB, separated by a Busy rise/fall
        strobe(0, 8'h0, 1, 16'h1234);
        wait_pulse("t2_p0", 5, d);
        check("t2_b0", {24'b0, d}, 32'h34);
        falls0 = busy_falls;
        wait_pulse("t2_p1", 40, d);
        check("t2_b1", {24'b0, d}, 32'h12);
        check("t2_handshake", {31'b0, (busy_falls > falls0)}, 32'd1);
        wait_idle("t2_idle", 40);

        // 3: simultaneous strobes
        strobe(1, 8'h77, 1, 16'hBEEF);
        wait_pulse("t3_p0", 5, d);  check("t3_b0", {24'b0, d}, 32'h77);
        wait_pulse("t3_p1", 40, d); check("t3_b1", {24'b0, d}, 32'hEF);
        wait_pulse("t3_p2", 40, d); check("t3_b2", {24'b0, d}, 32'hBE);
        check("t3_ovf", {31'b0, ovf_err}, 32'd0);
        wait_idle("t3_idle", 40);

        // 4: overflow with Busy held high and 3 bytes queued
        auto_busy = 0; man_busy = 1;
        strobe(1, 8'h11, 1, 16'h2233);
        strobe(0, 8'h0, 1, 16'h4455);
        @(negedge CLK);
        check("t4_ovf_set", {31'b0, ovf_err}, 32'd1);
        strobe(1, 8'h66, 0, 16'h0);
        repeat (3) @(negedge CLK);
        check("t4_blocked", {31'b0, sched_idle}, 32'd0);
        man_busy = 0; rise_dly = 3; hold_len = 4; auto_busy = 1;
        wait_pulse("t4_p0", 10, d); check("t4_b0", {24'b0, d}, 32'h11);
        wait_pulse("t4_p1", 40, d); check("t4_b1", {24'b0, d}, 32'h33);
        wait_pulse("t4_p2", 40, d); check("t4_b2", {24'b0, d}, 32'h22);
        wait_pulse("t4_p3", 40, d); check("t4_b3", {24'b0, d}, 32'h66);
        wait_idle("t4_idle", 40);
        check("t4_ovf_sticky", {31'b0, ovf_err}, 32'd1);

        // 5: Busy never rises -> timeout, next byte still sent
        check("t5_tmo_before", {31'b0, tmo_err}, 32'd0);
        auto_busy = 0; man_busy = 0;
        strobe(0, 8'h0, 1, 16'hCAFE);
        wait_pulse("t5_p0", 5, d);
        check("t5_b0", {24'b0, d}, 32'hFE);
        repeat (T) @(negedge CLK);
        check("t5_tmo_not_early", {31'b0, tmo_err}, 32'd0);
        @(negedge CLK);
        check("t5_tmo_exact", {31'b0, tmo_err}, 32'd1);
        @(negedge CLK);
        check("t5_next_pulse", {31'b0, TX_D_VALID}, 32'd1);
        check("t5_b1",         {24'b0, TX_P_DATA},  32'hCA);
        wait_idle("t5_idle", T + 10);

        // 6: asynchronous reset while in WAIT_LO with 2 bytes queued
        auto_busy = 1; rise_dly = 2; hold_len = 60;
        strobe(1, 8'h99, 1, 16'h5566);
        wait_pulse("t6_p0", 5, d);
        check("t6_b0", {24'b0, d}, 32'h99);
        repeat (6) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, TX_D_VALID}, 32'd0);
        check("t6_rst_data",  {24'b0, TX_P_DATA},  32'h00);
        check("t6_rst_idle",  {31'b0, sched_idle}, 32'd1);
        check("t6_rst_ovf",   {31'b0, ovf_err},    32'd0);
        check("t6_rst_tmo",   {31'b0, tmo_err},    32'd0);
        auto_busy = 0; man_busy = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (TX_D_VALID === 1'b1) pulses++;
        end
        check("t6_no_pulse", pulses, 32'd0);
        auto_busy = 1; rise_dly = 2; hold_len = 3;
        strobe(1, 8'h3C, 0, 16'h0);
        wait_pulse("t6_p1", 5, d);
        check("t6_b1", {24'b0, d}, 32'h3C);
        wait_idle("t6_idle", 40);

        // Randomized traffic with varying Busy behaviour
        heavy = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge CLK); #1;
            if (i % 400 == 0) heavy = ($urandom_range(0, 1) == 1);
            rise_dly = ($urandom_range(0, 9) == 0) ? T + 8 : int'($urandom_range(1, 10));
            hold_len = $urandom_range(1, 6);
            RdData   = 8'($urandom);
            ALU_OUT  = 16'($urandom);
            RdData_Valid = heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            OUT_Valid    = heavy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
        end
        @(posedge CLK); #1;
        RdData_Valid = 1'b0; OUT_Valid = 1'b0;
        repeat (100) @(posedge CLK);
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
